// File: rtl/keypad_operand_loader_if.sv
// Operand handshake bundle between the keypad operand loader and the FP adder.
// The master (loader) presents op_a/op_b with op_valid.
// The slave (adder) accepts the pair with op_ready.
`timescale 1ns/1ps
interface keypad_operand_loader_if;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;

  modport master (output op_valid, output op_a, output op_b, input op_ready);
  modport slave  (input op_valid, input op_a, input op_b, output op_ready);
endinterface

// File: rtl/keypad_operand_loader.sv
// keypad_operand_loader: turns keypad scanner events into a pair of
// half-precision operands and hands them to the FP adder over a
// valid/ready handshake.
//
// Keys: hex digits, '*' (shift, or clear when pressed twice) and '#' (enter).
// The first accepted enter loads op_a, the second loads op_b, and then the
// pair is presented until it is accepted.
//
// Optional build macro KLOAD_SPECIAL_FILTER_EN: when defined, an entry whose
// exponent field is all ones (Inf/NaN) is rejected on enter.
`timescale 1ns/1ps
module keypad_operand_loader #(
  parameter int DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           new_key,
  input  logic [3:0]                     new_key_char,
  keypad_operand_loader_if.master        op_if,
  output logic [15:0]                    entry,
  output logic [2:0]                     digit_cnt,
  output logic [1:0]                     phase,
  output logic                           shift_active,
  output logic                           err
);

  localparam int DATA_W = 4 * DIGITS;
  localparam logic [2:0] MAX_CNT = 3'(DIGITS);
`ifdef KLOAD_SPECIAL_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    PRESENT = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic       is_shift;
    logic       is_enter;
    logic [3:0] nib;
  } key_t;

  // Keypad matrix index to key meaning.
  function automatic key_t decode_key(input logic [3:0] idx);
    key_t k;
    k = '0;
    k.is_digit = 1'b1;
    case (idx)
      4'd0:  k.nib = 4'h1;
      4'd1:  k.nib = 4'h2;
      4'd2:  k.nib = 4'h3;
      4'd3:  k.nib = 4'hA;
      4'd4:  k.nib = 4'h4;
      4'd5:  k.nib = 4'h5;
      4'd6:  k.nib = 4'h6;
      4'd7:  k.nib = 4'hB;
      4'd8:  k.nib = 4'h7;
      4'd9:  k.nib = 4'h8;
      4'd10: k.nib = 4'h9;
      4'd11: k.nib = 4'hC;
      4'd12: begin k.is_digit = 1'b0; k.is_shift = 1'b1; end
      4'd13: k.nib = 4'h0;
      4'd14: begin k.is_digit = 1'b0; k.is_enter = 1'b1; end
      4'd15: k.nib = 4'hD;
      default: k.nib = 4'h0;
    endcase
    return k;
  endfunction

  // Shifted digit meaning: A becomes E, B becomes F, others unchanged.
  function automatic logic [3:0] shifted_nib(input logic [3:0] nib);
    logic [3:0] r;
    r = nib;
    if (nib == 4'hA) r = 4'hE;
    if (nib == 4'hB) r = 4'hF;
    return r;
  endfunction

  // Inf/NaN patterns are refused only when the filter is built in.
  function automatic logic is_special(input logic [DATA_W-1:0] v);
    return FILTER_EN && (v[14:10] == 5'b11111);
  endfunction

  state_t              state_q, state_d;
  logic                new_key_d_q;
  logic [DATA_W-1:0]   entry_q, entry_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                shift_q, shift_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic                op_valid_q, op_valid_d;
  logic                key_ev;
  key_t                key_w;
  logic [3:0]          nib_w;

  // One event per press: rising edge of the scanner flag.
  assign key_ev = new_key & ~new_key_d_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ENTER_A;
    else       state_q <= state_d;
  end

  // Next-state, entry editing and operand capture.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    err_d    = 1'b0;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    key_w    = decode_key(new_key_char);
    nib_w    = shift_q ? shifted_nib(key_w.nib) : key_w.nib;

    case (state_q)
      PRESENT: begin
        // Keys are ignored while the pair waits for the adder.
        if (op_if.op_ready) state_d = ENTER_A;
      end
      ENTER_A, ENTER_B: begin
        if (key_ev) begin
          if (key_w.is_shift) begin
            if (shift_q) begin
              entry_d = '0;
              cnt_d   = '0;
            end
            shift_d = ~shift_q;
          end else if (key_w.is_enter) begin
            shift_d = 1'b0;
            if (cnt_q == 3'd0) begin
              err_d = 1'b1;
            end else begin
              entry_d = '0;
              cnt_d   = '0;
              if (is_special(entry_q)) begin
                err_d = 1'b1;
              end else if (state_q == ENTER_A) begin
                op_a_d  = entry_q;
                state_d = ENTER_B;
              end else begin
                op_b_d  = entry_q;
                state_d = PRESENT;
              end
            end
          end else begin
            shift_d = 1'b0;
            if (cnt_q < MAX_CNT) begin
              entry_d = {entry_q[DATA_W-5:0], nib_w};
              cnt_d   = cnt_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ENTER_A;
    endcase

    op_valid_d = (state_d == PRESENT);
  end

  // Datapath and status registers; everything returns to zero on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_key_d_q <= 1'b0;
      entry_q     <= '0;
      cnt_q       <= '0;
      shift_q     <= 1'b0;
      err_q       <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
    end else begin
      new_key_d_q <= new_key;
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
    end
  end

  assign op_if.op_valid = op_valid_q;
  assign op_if.op_a     = op_a_q;
  assign op_if.op_b     = op_b_q;
  assign entry          = entry_q;
  assign digit_cnt      = cnt_q;
  assign phase          = state_q;
  assign shift_active   = shift_q;
  assign err            = err_q;

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Bench for keypad_operand_loader: directed key sequences followed by random
// key presses, all checked every cycle against a key-level reference model.
`timescale 1ns/1ps
module tb_keypad_operand_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_key = 1'b0;
  logic [3:0]  new_key_char = 4'd0;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic [1:0]  phase;
  logic        shift_active;
  logic        err;
  bit          rand_rdy = 1'b0;

  keypad_operand_loader_if op_if();

  keypad_operand_loader #(.DIGITS(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_key      (new_key),
    .new_key_char (new_key_char),
    .op_if        (op_if),
    .entry        (entry),
    .digit_cnt    (digit_cnt),
    .phase        (phase),
    .shift_active (shift_active),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: key meanings as numbers, typed digits kept as a queue.
  // -1 is shift '*', -2 is enter '#'.
  int key_map [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, -1, 0, -2, 13};
  int m_digits[$];
  bit m_shift, m_err, m_prev_key;
  int m_phase;
  int m_a, m_b;

  function automatic int m_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic bit m_rejects(int v);
`ifdef KLOAD_SPECIAL_FILTER_EN
    return ((v / 1024) % 32) == 31;
`else
    return (v < 0);
`endif
  endfunction

  function automatic void model_edge(bit rst, bit nk, int ch, bit rdy);
    bit ev;
    int k;
    if (rst) begin
      m_digits.delete();
      m_shift = 0; m_err = 0; m_prev_key = 0;
      m_phase = 0; m_a = 0; m_b = 0;
      return;
    end
    ev = nk && !m_prev_key;
    m_prev_key = nk;
    m_err = 0;
    if (m_phase == 2) begin
      if (rdy) m_phase = 0;
      return;
    end
    if (!ev) return;
    k = key_map[ch];
    if (k == -1) begin
      if (m_shift) m_digits.delete();
      m_shift = !m_shift;
    end else if (k == -2) begin
      m_shift = 0;
      if (m_digits.size() == 0) m_err = 1;
      else begin
        if (m_rejects(m_value())) m_err = 1;
        else if (m_phase == 0) begin m_a = m_value(); m_phase = 1; end
        else begin m_b = m_value(); m_phase = 2; end
        m_digits.delete();
      end
    end else begin
      if (m_shift && k == 10) k = 14;
      if (m_shift && k == 11) k = 15;
      m_shift = 0;
      if (m_digits.size() < 4) m_digits.push_back(k);
      else m_err = 1;
    end
  endfunction

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_edge(reset, new_key, int'(new_key_char), op_if.op_ready);
      #1;
      chk("op_valid", 32'(op_if.op_valid), 32'(m_phase == 2));
      chk("op_a", 32'(op_if.op_a), m_a);
      chk("op_b", 32'(op_if.op_b), m_b);
      chk("entry", 32'(entry), m_value());
      chk("digit_cnt", 32'(digit_cnt), m_digits.size());
      chk("phase", 32'(phase), m_phase);
      chk("shift_active", 32'(shift_active), 32'(m_shift));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) op_if.op_ready = ($urandom_range(0, 3) == 0);
  endtask

  task automatic press(input logic [3:0] c, input int hold, input int gap);
    tick();
    new_key = 1'b1;
    new_key_char = c;
    repeat (hold) tick();
    new_key = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic press_seq(input int keys[$]);
    foreach (keys[i]) press(4'(keys[i]), 1, 0);
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
  endtask

  task automatic handshake();
    tick(); op_if.op_ready = 1'b1;
    tick(); op_if.op_ready = 1'b0;
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    op_if.op_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_entry", 32'(entry), 0);
    chk("reset_valid", 32'(op_if.op_valid), 0);

    // 3C00 then 4000, presented and held without ready.
    press_seq('{2, 11, 13, 13, 14, 4, 13, 13, 13, 14});
    repeat (3) tick();
    chk("pair_valid", 32'(op_if.op_valid), 1);
    chk("pair_a", 32'(op_if.op_a), 32'h3C00);
    chk("pair_b", 32'(op_if.op_b), 32'h4000);
    handshake();
    chk("xfer_valid", 32'(op_if.op_valid), 0);
    chk("xfer_phase", 32'(phase), 0);
    chk("xfer_hold_a", 32'(op_if.op_a), 32'h3C00);

    // Shifted digits: *A *B C D # gives EFCD.
    press(4'd12, 1, 0); chk("shift_on1", 32'(shift_active), 1);
    press(4'd3, 1, 0);  chk("shift_off1", 32'(shift_active), 0);
    press(4'd12, 1, 0); chk("shift_on2", 32'(shift_active), 1);
    press(4'd7, 1, 0);  chk("shift_off2", 32'(shift_active), 0);
    press_seq('{11, 15, 14});
    chk("shift_opa", 32'(op_if.op_a), 32'hEFCD);

    // Overflowing the entry, then double-shift clear.
    press_seq('{0, 1, 2, 4});
    press(4'd5, 1, 0);
    chk("full_err", 32'(err), 1);
    chk("full_entry", 32'(entry), 32'h1234);
    chk("full_cnt", 32'(digit_cnt), 4);
    tick();
    chk("err_one_cycle", 32'(err), 0);
    press_seq('{12, 12});
    chk("clr_entry", 32'(entry), 0);
    chk("clr_cnt", 32'(digit_cnt), 0);

    // Long hold counts once; empty enter is rejected.
    press(4'd13, 10, 0);
    chk("hold_cnt", 32'(digit_cnt), 1);
    press_seq('{12, 12});
    press(4'd14, 1, 0);
    chk("empty_err", 32'(err), 1);
    chk("empty_phase", 32'(phase), 1);

    // Finish B, then keys during PRESENT are ignored.
    press_seq('{4, 13, 13, 13, 14});
    press_seq('{0, 12, 14, 5});
    chk("present_entry", 32'(entry), 0);
    chk("present_b", 32'(op_if.op_b), 32'h4000);
    handshake();

    // Reset in the middle of an entry.
    press_seq('{0, 1, 2, 4, 14, 5, 6});
    do_reset();
    chk("rst_a", 32'(op_if.op_a), 0);
    chk("rst_entry", 32'(entry), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_cnt", 32'(digit_cnt), 0);

    // 7C00 is Inf: refused only when the filter is built in.
    press_seq('{8, 11, 13, 13, 14});
`ifdef KLOAD_SPECIAL_FILTER_EN
    chk("inf_err", 32'(err), 1);
    chk("inf_phase", 32'(phase), 0);
    chk("inf_a", 32'(op_if.op_a), 0);
`else
    chk("inf_a", 32'(op_if.op_a), 32'h7C00);
    chk("inf_phase", 32'(phase), 1);
`endif
    do_reset();

    // Random presses with random ready, occasional resets.
    rand_rdy = 1'b1;
    for (int i = 0; i < 500; i++) begin
      logic [3:0] c;
      c = ($urandom_range(0, 5) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      press(c, $urandom_range(1, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) do_reset();
    end
    rand_rdy = 1'b0;
    op_if.op_ready = 1'b0;
    if (m_phase == 2) handshake();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
